// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-PC generator: redirect opcodes, default vectors, offset helper.
package pc_gen_pkg;

  localparam int PC_OP_W = 3;

  localparam logic [PC_OP_W-1:0] PC_OP_SEQ  = 3'b000;
  localparam logic [PC_OP_W-1:0] PC_OP_B    = 3'b001;
  localparam logic [PC_OP_W-1:0] PC_OP_J    = 3'b010;
  localparam logic [PC_OP_W-1:0] PC_OP_CALL = 3'b011;
  localparam logic [PC_OP_W-1:0] PC_OP_R    = 3'b100;
  localparam logic [PC_OP_W-1:0] PC_OP_RET  = 3'b101;
  localparam logic [PC_OP_W-1:0] PC_OP_EXC  = 3'b110;
  localparam logic [PC_OP_W-1:0] PC_OP_RSV  = 3'b111;

  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_4180;

  // Word offset sign-extended to the widest supported PC; callers truncate to ADDR_W.
  function automatic logic [63:0] word_off_sext(input logic [15:0] imm);
    return {{46{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Redirect-request / fetch-PC bus between the resolving stage (master) and pc_gen (slave).
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic               stall_i;
  logic [PC_OP_W-1:0] op_i;
  logic [ADDR_W-1:0]  br_pc_i;
  logic [15:0]        b_imm_i;
  logic [25:0]        j_imm_i;
  logic [ADDR_W-1:0]  rs_i;
  logic [ADDR_W-1:0]  pc_o;
  logic               flush_o;
  logic               pend_o;

  modport master (
    output stall_i, op_i, br_pc_i, b_imm_i, j_imm_i, rs_i,
    input  pc_o, flush_o, pend_o
  );

  modport slave (
    input  stall_i, op_i, br_pc_i, b_imm_i, j_imm_i, rs_i,
    output pc_o, flush_o, pend_o
  );
endinterface

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry, a pop when empty is a no-op.
module pc_gen_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0] ptr_q, ptr_d, wr_idx_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wr_idx_s = ptr_q + IDX_W'(1);
  assign top_o    = mem_q[ptr_q];
  assign empty_o  = (cnt_q == {CNT_W{1'b0}});

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = wr_idx_s;
      if (cnt_q == CNT_W'(DEPTH)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - IDX_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= {IDX_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push_i) begin
        mem_q[wr_idx_s] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator with stall hold, pending-redirect latch, exception vector and flush pulse.
// Define PC_GEN_RAS_EN to add the return-address stack used by CALL / RET.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC_DEF),
  parameter int              RAS_DEPTH = 4
) (
  input logic    clk,
  input logic    reset,
  pc_gen_if.slave bus
);
  logic [ADDR_W-1:0] pc_q, pc_d, ptgt_q, ptgt_d;
  logic              pend_q, pend_d, flush_q, flush_d;
  logic [ADDR_W-1:0] pc4_s, b_tgt_s, j_tgt_s, ret_tgt_s, tgt_s;
  logic              redir_s, is_exc_s;

  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_ras_depth
    $error("pc_gen: RAS_DEPTH must be a power of 2, at least 2");
  end

  assign pc4_s    = bus.br_pc_i + ADDR_W'(4);
  assign b_tgt_s  = pc4_s + ADDR_W'(word_off_sext(bus.b_imm_i));
  assign is_exc_s = (bus.op_i == PC_OP_EXC);

  if (ADDR_W > 28) begin : g_j_region
    assign j_tgt_s = {pc4_s[ADDR_W-1:28], bus.j_imm_i, 2'b00};
  end else begin : g_j_flat
    assign j_tgt_s = {bus.j_imm_i, 2'b00};
  end

`ifdef PC_GEN_RAS_EN
  logic              op_taken_s, ras_push_s, ras_pop_s, ras_empty_s;
  logic [ADDR_W-1:0] ras_top_s;

  // While a latched redirect is being released the op is ignored, so the stack must not move either.
  assign op_taken_s = bus.stall_i | ~pend_q;
  assign ras_push_s = op_taken_s & (bus.op_i == PC_OP_CALL);
  assign ras_pop_s  = op_taken_s & (bus.op_i == PC_OP_RET);
  assign ret_tgt_s  = ras_empty_s ? bus.rs_i : ras_top_s;

  pc_gen_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ras_push_s),
    .pop_i       (ras_pop_s),
    .push_data_i (pc4_s),
    .top_o       (ras_top_s),
    .empty_o     (ras_empty_s)
  );
`else
  assign ret_tgt_s = bus.rs_i;
`endif

  always_comb begin
    tgt_s   = {ADDR_W{1'b0}};
    redir_s = 1'b0;
    case (bus.op_i)
      PC_OP_B: begin
        tgt_s   = b_tgt_s;
        redir_s = 1'b1;
      end
      PC_OP_J, PC_OP_CALL: begin
        tgt_s   = j_tgt_s;
        redir_s = 1'b1;
      end
      PC_OP_R: begin
        tgt_s   = bus.rs_i;
        redir_s = 1'b1;
      end
      PC_OP_RET: begin
        tgt_s   = ret_tgt_s;
        redir_s = 1'b1;
      end
      default: begin
        tgt_s   = {ADDR_W{1'b0}};
        redir_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    pend_d  = pend_q;
    ptgt_d  = ptgt_q;
    flush_d = 1'b0;
    if (is_exc_s) begin
      pc_d    = EXC_VEC;
      pend_d  = 1'b0;
      ptgt_d  = {ADDR_W{1'b0}};
      flush_d = 1'b1;
    end else if (bus.stall_i) begin
      if (redir_s) begin
        ptgt_d = tgt_s;
        pend_d = 1'b1;
      end else begin
        ptgt_d = ptgt_q;
        pend_d = pend_q;
      end
    end else if (pend_q) begin
      pc_d    = ptgt_q;
      pend_d  = 1'b0;
      flush_d = 1'b1;
    end else if (redir_s) begin
      pc_d    = tgt_s;
      flush_d = 1'b1;
    end else begin
      pc_d    = pc_q + ADDR_W'(4);
      flush_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      pend_q  <= 1'b0;
      ptgt_q  <= {ADDR_W{1'b0}};
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_o    = pc_q;
  assign bus.flush_o = flush_q;
  assign bus.pend_o  = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand sequences, and randomized ops against a reference model.
module tb_pc_gen;
  localparam int RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(32)) bus ();

  pc_gen #(
    .ADDR_W    (32),
    .RESET_VEC (32'h0000_3000),
    .EXC_VEC   (32'h0000_4180),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic [31:0] br;
    logic [15:0] bi;
    logic [25:0] ji;
    logic [31:0] rs;
    logic [31:0] epc;
    logic        ef;
    logic        ep;
  } vec_t;

  // Reference model state: architectural PC, pending redirect, flush, and a LIFO held as a queue.
  logic [31:0] m_pc, m_ptgt;
  logic        m_pend, m_flush;
  logic [31:0] ras_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_3000;
    m_ptgt  = 32'h0;
    m_pend  = 1'b0;
    m_flush = 1'b0;
    ras_q.delete();
  endtask

  task automatic model_step(input logic st, input logic [2:0] op, input logic [31:0] br,
                            input logic [15:0] bi, input logic [25:0] ji, input logic [31:0] rs);
    logic [31:0] tgt;
    logic        redir, taken;
    int          off;
    off   = int'($signed(bi));
    redir = (op >= 3'd1) && (op <= 3'd5);
    taken = st || !m_pend;
    tgt   = 32'h0;
    case (op)
      3'd1: tgt = br + 32'd4 + 32'(off * 4);
      3'd2, 3'd3: tgt = ((br + 32'd4) & 32'hF000_0000) | (32'(ji) * 32'd4);
      3'd4: tgt = rs;
      3'd5: begin
        tgt = rs;
`ifdef PC_GEN_RAS_EN
        if (taken && ras_q.size() > 0) tgt = ras_q.pop_back();
`endif
      end
      default: tgt = 32'h0;
    endcase
`ifdef PC_GEN_RAS_EN
    if (taken && op == 3'd3) begin
      ras_q.push_back(br + 32'd4);
      if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
    end
`endif
    if (op == 3'd6) begin
      m_pc = 32'h0000_4180; m_pend = 1'b0; m_flush = 1'b1;
    end else if (st) begin
      m_flush = 1'b0;
      if (redir) begin m_ptgt = tgt; m_pend = 1'b1; end
    end else if (m_pend) begin
      m_pc = m_ptgt; m_pend = 1'b0; m_flush = 1'b1;
    end else if (redir) begin
      m_pc = tgt; m_flush = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4; m_flush = 1'b0;
    end
  endtask

  task automatic drive_edge(input logic st, input logic [2:0] op, input logic [31:0] br,
                            input logic [15:0] bi, input logic [25:0] ji, input logic [31:0] rs);
    bus.stall_i = st;
    bus.op_i    = op;
    bus.br_pc_i = br;
    bus.b_imm_i = bi;
    bus.j_imm_i = ji;
    bus.rs_i    = rs;
    model_step(st, op, br, bi, ji, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] epc, input logic ef, input logic ep);
    check({tag, "_pc"}, bus.pc_o, epc);
    check({tag, "_flush"}, 32'(bus.flush_o), 32'(ef));
    check({tag, "_pend"}, 32'(bus.pend_o), 32'(ep));
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] op, input logic [31:0] br,
                              input logic [15:0] bi, input logic [25:0] ji, input logic [31:0] rs,
                              input logic [31:0] epc, input logic ef, input logic ep);
    vec_t v;
    v.stall = st; v.op = op; v.br = br; v.bi = bi; v.ji = ji; v.rs = rs;
    v.epc = epc; v.ef = ef; v.ep = ep;
    return v;
  endfunction

  vec_t        vecs[25];
  logic [31:0] ret_exp;

  initial begin
    vecs[0]  = mk(1'b0, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_3004, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_3008, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_300C, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 3'd1, 32'h3008,     16'hFFFF, 26'h0,     32'h0,        32'h0000_3008, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 3'd2, 32'h3010,     16'h0,    26'h0C00,  32'h0,        32'h0000_3000, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_3004, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 3'd4, 32'h0,        16'h0,    26'h0,     32'h3400,     32'h0000_3004, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_3004, 1'b0, 1'b1);
    vecs[8]  = mk(1'b1, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_3004, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_3400, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_3404, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 3'd2, 32'h3000,     16'h0,    26'h0D00,  32'h0,        32'h0000_3404, 1'b0, 1'b1);
    vecs[12] = mk(1'b1, 3'd6, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_4180, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_4184, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 3'd1, 32'h4184,     16'h0010, 26'h0,     32'h0,        32'h0000_4184, 1'b0, 1'b1);
    vecs[15] = mk(1'b1, 3'd4, 32'h0,        16'h0,    26'h0,     32'h5000,     32'h0000_4184, 1'b0, 1'b1);
    vecs[16] = mk(1'b0, 3'd2, 32'h0,        16'h0,    26'h0100,  32'h0,        32'h0000_5000, 1'b1, 1'b0);
    vecs[17] = mk(1'b0, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_5004, 1'b0, 1'b0);
    vecs[18] = mk(1'b0, 3'd4, 32'h0,        16'h0,    26'h0,     32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0);
    vecs[19] = mk(1'b0, 3'd0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_0000, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 3'd7, 32'h1234,     16'h5,    26'h77,    32'h8888,     32'h0000_0004, 1'b0, 1'b0);
    vecs[21] = mk(1'b0, 3'd6, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_4180, 1'b1, 1'b0);
    vecs[22] = mk(1'b0, 3'd1, 32'hA000_0000, 16'h8000, 26'h0,    32'h0,        32'h9FFE_0004, 1'b1, 1'b0);
    vecs[23] = mk(1'b0, 3'd3, 32'h3000,     16'h0,    26'h0C10,  32'h0,        32'h0000_3040, 1'b1, 1'b0);
`ifdef PC_GEN_RAS_EN
    ret_exp = 32'h0000_3004;
`else
    ret_exp = 32'h0000_3500;
`endif
    vecs[24] = mk(1'b0, 3'd5, 32'h0,        16'h0,    26'h0,     32'h3500,     ret_exp,       1'b1, 1'b0);

    bus.stall_i = 1'b0; bus.op_i = 3'd0; bus.br_pc_i = 32'h0;
    bus.b_imm_i = 16'h0; bus.j_imm_i = 26'h0; bus.rs_i = 32'h0;

    // Reset pulse in the middle of a cycle must take effect immediately.
    #12 reset = 1'b1;
    #1 check_outs("reset", 32'h0000_3000, 1'b0, 1'b0);
    #1 reset = 1'b0;
    model_reset();

    foreach (vecs[i]) begin
      drive_edge(vecs[i].stall, vecs[i].op, vecs[i].br, vecs[i].bi, vecs[i].ji, vecs[i].rs);
      check_outs($sformatf("vec%0d", i), vecs[i].epc, vecs[i].ef, vecs[i].ep);
    end

    // Reset while a redirect is pending discards it.
    drive_edge(1'b1, 3'd1, 32'h3000, 16'h0040, 26'h0, 32'h0);
    check_outs("prepend", 32'h0000_3500 - ((ret_exp == 32'h0000_3500) ? 32'h0 : 32'h0000_04FC) + 32'h0, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 check_outs("midpend_reset", 32'h0000_3000, 1'b0, 1'b0);
    #1 reset = 1'b0;
    model_reset();
    drive_edge(1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    check_outs("after_reset", 32'h0000_3004, 1'b0, 1'b0);

    // Five calls into a four-deep stack, then unwind.
    for (int k = 0; k < 5; k++) begin
      drive_edge(1'b0, 3'd3, 32'h1000 * (k + 1), 16'h0, 26'h0, 32'h0);
      check_outs($sformatf("call%0d", k), 32'h0, 1'b1, 1'b0);
    end
    for (int k = 4; k >= 1; k--) begin
`ifdef PC_GEN_RAS_EN
      ret_exp = 32'h1000 * (k + 1) + 32'd4;
`else
      ret_exp = 32'h0000_ABC0;
`endif
      drive_edge(1'b0, 3'd5, 32'h0, 16'h0, 26'h0, 32'h0000_ABC0);
      check_outs($sformatf("ret%0d", k), ret_exp, 1'b1, 1'b0);
    end
    drive_edge(1'b0, 3'd5, 32'h0, 16'h0, 26'h0, 32'h0000_ABC0);
    check_outs("ret_empty", 32'h0000_ABC0, 1'b1, 1'b0);

    // Randomized ops against the reference model.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      int          r;
      logic [2:0]  op;
      r = int'($urandom_range(0, 19));
      if (r < 8)       op = 3'd0;
      else if (r < 18) op = 3'($urandom_range(1, 5));
      else if (r == 18) op = 3'd7;
      else             op = 3'd6;
      drive_edge(($urandom_range(0, 9) < 3), op, $urandom & 32'hFFFF_FFFC, 16'($urandom),
                 26'($urandom), $urandom & 32'hFFFF_FFFC);
      check_outs($sformatf("rand%0d", n), m_pc, m_flush, m_pend);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
